// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Module   : mem_bus_arbiter_pkg
// Summary  : State encodings and master IDs shared by the memory bus arbiter.
// Revision : 1.0
//==============================================================================
package mem_bus_arbiter_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DMA  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MID_M0 = 2'd0,
        MID_M1 = 2'd1,
        MID_M2 = 2'd2
    } master_id_t;

    function automatic master_id_t rr_id(input logic gnt);
        return gnt ? MID_M1 : MID_M0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_rr_pick2.sv
`default_nettype none
//==============================================================================
// Module   : mem_bus_arbiter_rr_pick2
// Summary  : Combinational 2-way round-robin picker; a tie goes to the master
//            that did not win last.
// Revision : 1.0
//==============================================================================
module mem_bus_arbiter_rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       grant_id_o,
    output logic       valid_o
);

    always_comb begin
        valid_o    = |req_i;
        grant_id_o = 1'b0;
        case (req_i)
            2'b01:   grant_id_o = 1'b0;
            2'b10:   grant_id_o = 1'b1;
            2'b11:   grant_id_o = ~last_i;
            default: grant_id_o = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : mem_bus_arbiter
// Summary  : Shares one memory port between I-cache (M0), D-side (M1) and an
//            external DMA device (M2, BR/BG handshake).
// Revision : 1.0
//==============================================================================
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int WORD_SIZE   = 16,
    parameter int LINE_BITS   = 64,
    parameter int MEM_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 m0_readM,
    input  logic [WORD_SIZE-1:0] m0_address,
    output logic [LINE_BITS-1:0] m0_rdata,
    output logic                 m0_ready,
    input  logic                 m1_readM,
    input  logic                 m1_writeM,
    input  logic [WORD_SIZE-1:0] m1_address,
    input  logic [LINE_BITS-1:0] m1_wdata,
    output logic [LINE_BITS-1:0] m1_rdata,
    output logic                 m1_ready,
    input  logic                 dma_br,
    output logic                 dma_bg,
    output logic                 mem_readM,
    output logic                 mem_writeM,
    output logic [WORD_SIZE-1:0] mem_address,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic [LINE_BITS-1:0] mem_rdata,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    master_id_t             owner_q, owner_d;
    master_id_t             rr_last_q, rr_last_d;
    logic                   wr_q, wr_d;
    logic [WORD_SIZE-1:0]   addr_q, addr_d;
    logic [LINE_BITS-1:0]   wdata_q, wdata_d;
    logic [LINE_BITS-1:0]   m0_rdata_q, m0_rdata_d;
    logic [LINE_BITS-1:0]   m1_rdata_q, m1_rdata_d;

    logic [1:0]             w_req;
    logic                   w_gnt;
    logic                   w_valid;

    assign w_req = {m1_readM | m1_writeM, m0_readM};

    mem_bus_arbiter_rr_pick2 u_pick (
        .req_i      (w_req),
        .last_i     (rr_last_q == MID_M1),
        .grant_id_o (w_gnt),
        .valid_o    (w_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            owner_q    <= MID_M0;
            rr_last_q  <= MID_M1;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            rr_last_q  <= rr_last_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        rr_last_d   = rr_last_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        m0_ready    = 1'b0;
        m1_ready    = 1'b0;
        dma_bg      = 1'b0;
        mem_readM   = 1'b0;
        mem_writeM  = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;

        case (state_q)
            ST_IDLE: begin
                if (dma_br) begin
                    state_d = ST_DMA;
                end else if (w_valid) begin
                    state_d = ST_XFER;
                    cnt_d   = LAT;
                    owner_d = rr_id(w_gnt);
                    if (w_gnt) begin
                        addr_d  = m1_address;
                        wr_d    = m1_writeM;
                        wdata_d = m1_writeM ? m1_wdata : '0;
                    end else begin
                        addr_d  = m0_address;
                        wr_d    = 1'b0;
                        wdata_d = '0;
                    end
                end
            end
            ST_XFER: begin
                mem_readM   = ~wr_q;
                mem_writeM  = wr_q;
                mem_address = addr_q;
                mem_wdata   = wdata_q;
                cnt_d       = cnt_q - ONE;
                // Final latency cycle: read data is forwarded straight to the
                // owner alongside ready, and captured so it holds afterwards.
                if (cnt_q == ONE) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    rr_last_d = owner_q;
                    if (owner_q == MID_M1) begin
                        m1_ready = 1'b1;
                        if (!wr_q) begin
                            m1_rdata_d = mem_rdata;
                        end
                    end else begin
                        m0_ready = 1'b1;
                        if (!wr_q) begin
                            m0_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            ST_DMA: begin
                dma_bg = 1'b1;
                if (!dma_br) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign m0_rdata = m0_rdata_d;
    assign m1_rdata = m1_rdata_d;
    assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_mem_bus_arbiter
// Summary  : Directed scoreboard bench for mem_bus_arbiter.
// Revision : 1.0
//==============================================================================
module tb_mem_bus_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_readM;
    logic [15:0] m0_address;
    logic [63:0] m0_rdata;
    logic        m0_ready;
    logic        m1_readM;
    logic        m1_writeM;
    logic [15:0] m1_address;
    logic [63:0] m1_wdata;
    logic [63:0] m1_rdata;
    logic        m1_ready;
    logic        dma_br;
    logic        dma_bg;
    logic        mem_readM;
    logic        mem_writeM;
    logic [15:0] mem_address;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        busy;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .WORD_SIZE   (16),
        .LINE_BITS   (64),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .m0_readM    (m0_readM),
        .m0_address  (m0_address),
        .m0_rdata    (m0_rdata),
        .m0_ready    (m0_ready),
        .m1_readM    (m1_readM),
        .m1_writeM   (m1_writeM),
        .m1_address  (m1_address),
        .m1_wdata    (m1_wdata),
        .m1_rdata    (m1_rdata),
        .m1_ready    (m1_ready),
        .dma_br      (dma_br),
        .dma_bg      (dma_bg),
        .mem_readM   (mem_readM),
        .mem_writeM  (mem_writeM),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    // Memory returns a line derived from the address it is given.
    function automatic logic [63:0] mem_model(input logic [15:0] a);
        return {4{a ^ 16'hA5A5}};
    endfunction

    assign mem_rdata = mem_model(mem_address);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          id;
        bit          rd;
        logic [15:0] addr;
        int          cyc;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_txn(input int id, input bit rd, input logic [15:0] addr, input int c);
        exp_t e;
        e.id   = id;
        e.rd   = rd;
        e.addr = addr;
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        m0_readM   = 1'b0;
        m1_readM   = 1'b0;
        m1_writeM  = 1'b0;
        dma_br     = 1'b0;
        m0_address = '0;
        m1_address = '0;
        m1_wdata   = '0;
        tick(2);
        reset_n = 1'b1;
    endtask

    // Monitor: every ready pulse is matched against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (m0_ready && m1_ready) begin
                checks++;
                failures++;
                $display("FAIL dual_ready: got m0_ready=%b m1_ready=%b expected one-hot (cycle %0d)",
                         m0_ready, m1_ready, cyc);
            end else if (m0_ready || m1_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_ready", {62'd0, m1_ready, m0_ready}, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("ready_id", m1_ready ? 64'd1 : 64'd0, 64'(e.id));
                    chk("ready_cycle", 64'(cyc), 64'(e.cyc));
                    if (e.rd) begin
                        chk("ready_rdata", (e.id == 1) ? m1_rdata : m0_rdata, mem_model(e.addr));
                    end
                end
            end
        end
    end

    initial begin
        int t;
        do_reset();
        tick(1);

        // Reset values
        chk("rst_busy",   64'(busy), 64'd0);
        chk("rst_bg",     64'(dma_bg), 64'd0);
        chk("rst_rd",     64'(mem_readM), 64'd0);
        chk("rst_wr",     64'(mem_writeM), 64'd0);
        chk("rst_addr",   64'(mem_address), 64'd0);
        chk("rst_wdata",  mem_wdata, 64'd0);
        chk("rst_m0rdy",  64'(m0_ready), 64'd0);
        chk("rst_m1rdy",  64'(m1_ready), 64'd0);
        chk("rst_m0data", m0_rdata, 64'd0);
        chk("rst_m1data", m1_rdata, 64'd0);

        // T1: lone I-cache read
        t = cyc;
        m0_readM   = 1'b1;
        m0_address = 16'h0010;
        expect_txn(0, 1'b1, 16'h0010, t + LAT);
        tick(1);
        chk("t1_rd_strobe", 64'(mem_readM), 64'd1);
        chk("t1_wr_strobe", 64'(mem_writeM), 64'd0);
        chk("t1_addr",      64'(mem_address), 64'h0010);
        chk("t1_busy",      64'(busy), 64'd1);
        tick(LAT);
        m0_readM = 1'b0;
        chk("t1_idle",      64'(busy), 64'd0);
        chk("t1_rdata_hold", m0_rdata, mem_model(16'h0010));

        // T2: tie after reset, both held -> M0, M1, M0, M1
        do_reset();
        t = cyc;
        m0_readM   = 1'b1;
        m0_address = 16'h0200;
        m1_readM   = 1'b1;
        m1_address = 16'h0300;
        expect_txn(0, 1'b1, 16'h0200, t + LAT);
        expect_txn(1, 1'b1, 16'h0300, t + 2 * LAT + 1);
        expect_txn(0, 1'b1, 16'h0200, t + 3 * LAT + 2);
        expect_txn(1, 1'b1, 16'h0300, t + 4 * LAT + 3);
        tick(4 * (LAT + 1));
        m0_readM = 1'b0;
        m1_readM = 1'b0;
        tick(1);

        // T3: D-side write
        t = cyc;
        m1_writeM  = 1'b1;
        m1_address = 16'h0100;
        m1_wdata   = 64'hDEAD_BEEF_0123_4567;
        expect_txn(1, 1'b0, 16'h0100, t + LAT);
        for (int k = 0; k < LAT; k++) begin
            tick(1);
            chk("t3_wr_strobe", 64'(mem_writeM), 64'd1);
            chk("t3_rd_strobe", 64'(mem_readM), 64'd0);
            chk("t3_addr",      64'(mem_address), 64'h0100);
            chk("t3_wdata",     mem_wdata, 64'hDEAD_BEEF_0123_4567);
        end
        tick(1);
        m1_writeM = 1'b0;
        chk("t3_wr_done",   64'(mem_writeM), 64'd0);
        chk("t3_rdata_hold", m1_rdata, mem_model(16'h0300));
        tick(1);

        // T4: DMA request during an M1 read, M0 queued behind it
        t = cyc;
        m1_readM   = 1'b1;
        m1_address = 16'h0400;
        expect_txn(1, 1'b1, 16'h0400, t + LAT);
        tick(2);
        dma_br     = 1'b1;
        m0_readM   = 1'b1;
        m0_address = 16'h0500;
        chk("t4_bg_wait2", 64'(dma_bg), 64'd0);
        tick(1);
        chk("t4_bg_wait3", 64'(dma_bg), 64'd0);
        tick(1);
        chk("t4_bg_wait4", 64'(dma_bg), 64'd0);
        tick(1);
        m1_readM = 1'b0;
        chk("t4_bg_wait5", 64'(dma_bg), 64'd0);
        tick(1);
        chk("t4_bg_on",    64'(dma_bg), 64'd1);
        chk("t4_dma_rd",   64'(mem_readM), 64'd0);
        chk("t4_dma_addr", 64'(mem_address), 64'd0);
        chk("t4_dma_busy", 64'(busy), 64'd1);
        tick(1);
        dma_br = 1'b0;
        chk("t4_bg_hold",  64'(dma_bg), 64'd1);
        tick(1);
        chk("t4_bg_off",   64'(dma_bg), 64'd0);
        expect_txn(0, 1'b1, 16'h0500, t + 12);
        tick(5);
        m0_readM = 1'b0;
        tick(1);

        // T5: reset while the counter sits at 2
        t = cyc;
        m0_readM   = 1'b1;
        m0_address = 16'h0600;
        tick(3);
        reset_n  = 1'b0;
        m0_readM = 1'b0;
        tick(1);
        chk("t5_no_ready", 64'(m0_ready), 64'd0);
        chk("t5_busy",     64'(busy), 64'd0);
        chk("t5_rd",       64'(mem_readM), 64'd0);
        chk("t5_addr",     64'(mem_address), 64'd0);
        chk("t5_m0data",   m0_rdata, 64'd0);
        chk("t5_m1data",   m1_rdata, 64'd0);
        reset_n = 1'b1;
        tick(1);
        t = cyc;
        m1_readM   = 1'b1;
        m1_address = 16'h0700;
        expect_txn(1, 1'b1, 16'h0700, t + LAT);
        tick(LAT + 1);
        m1_readM = 1'b0;
        tick(1);

        // T6: M1 held for three back-to-back transfers
        t = cyc;
        m1_readM   = 1'b1;
        m1_address = 16'h0800;
        expect_txn(1, 1'b1, 16'h0800, t + LAT);
        expect_txn(1, 1'b1, 16'h0800, t + 2 * LAT + 1);
        expect_txn(1, 1'b1, 16'h0800, t + 3 * LAT + 2);
        tick(3 * (LAT + 1));
        m1_readM = 1'b0;

        for (int i = 0; i < 50 && q.size() > 0; i++) tick(1);
        chk("pending_txns", 64'(q.size()), 64'd0);
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
